noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Router input-port stage directly upstream of the 1-to-5 output demultiplexer.
- Buffers incoming flits in a small FIFO and performs XY route computation on each head flit.
- Locks the selected output for the whole packet (wormhole) and drives the 3-bit output select plus a valid/ready flit stream into the demux.
- One instance per router input (local, N, E, S, W).

Parameters:
- DATA_W, 32, flit payload width.
- DEPTH, 4, FIFO depth in flits. Must be a power of 2 and at least 2.
- X_W, 2, width of the X coordinate.
- Y_W, 2, width of the Y coordinate.
- CUR_X, 0, X coordinate of this router.
- CUR_Y, 0, Y coordinate of this router.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  FIFO can accept a flit.
- in_data  in  DATA_W  flit payload. In a head flit, bits [X_W+Y_W-1:Y_W] hold dest_x and bits [Y_W-1:0] hold dest_y.
- in_head  in  1  flit is a packet head.
- in_tail  in  1  flit is a packet tail. Head and tail both set means a single-flit packet.
- out_valid  out  1  flit presented to the demux.
- out_ready  in  1  downstream accepts the flit.
- out_data  out  DATA_W  flit payload.
- out_head  out  1  head flag of the presented flit.
- out_tail  out  1  tail flag of the presented flit.
- out_sel  out  3  demux control: 000 local, 001 north, 010 east, 011 south, 100 west.
- busy  out  1  route locked (state ACTIVE).
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0) values: FIFO empty, count=0, pointers=0, state IDLE, out_sel=000, out_valid=0, busy=0, err=0. in_ready=1 once reset is released.
- FIFO:
  - Width DATA_W+2 (payload + head + tail).
  - push = in_valid & in_ready; in_ready = (count != DEPTH).
  - pop = out_valid & out_ready.
  - Simultaneous push and pop leave count unchanged.
  - When full, in_ready=0, so no push even if pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Output is first-word-fall-through: out_data/out_head/out_tail come combinationally from the read pointer.
- Route function (XY, evaluated on the FIFO head flit), in priority order:
  - dest_x > CUR_X -> 010 (east)
  - dest_x < CUR_X -> 100 (west)
  - else dest_y > CUR_Y -> 001 (north)
  - else dest_y < CUR_Y -> 011 (south)
  - else -> 000 (local)
  - Comparisons are unsigned.
- FSM:
  - IDLE:
    - out_valid=0.
    - FIFO non-empty and head flag set: register out_sel = route(head flit), go to ACTIVE. No pop this cycle.
    - FIFO non-empty and head flag clear: pop and discard the flit, set err. Stay IDLE.
  - ACTIVE:
    - busy=1, out_valid = (count != 0). out_sel held constant.
    - On a pop with tail flag set, return to IDLE at the next edge. out_sel holds its last value.
    - A head flag seen on a non-first flit while ACTIVE sets err; the flit is forwarded unchanged.
- Latency:
  - Head flit written at edge t into an empty FIFO in IDLE: visible in FIFO at t, route registered at t+1, out_valid=1 from t+1.
  - Minimum in-to-out latency is 2 cycles for a head flit.
  - Body flits stream with 1 cycle of FIFO latency and full throughput of 1 flit/cycle when out_ready=1.
- Back-to-back packets: after a tail pop there is a 1-cycle IDLE bubble before the next head is routed.
- out_ready may be held low indefinitely: out_valid and out_data stay stable while stalled (no retraction).
- Reset mid-packet: all state is cleared immediately and the in-flight packet is lost.

Test Plan:
- CUR=(1,1). Single-flit packet, dest (3,1), out_ready=1 -> out_sel=010, out_valid high one cycle, 2 cycles after push, then busy=0.
- CUR=(1,1). Four 3-flit packets with dest (0,1), (1,2), (1,0), (1,1) -> out_sel 100, 001, 011, 000 respectively; each held for 3 pops; 1-cycle bubble between packets.
- Hold out_ready=0, push DEPTH+2 flits -> in_ready drops after 4 pushes, count=4. Release out_ready -> all flits emerge in order with payloads intact.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, no push that cycle, count=3, then refill.
- Body flit (head=0) arriving while IDLE -> discarded, err=1 and stays 1, next proper packet routes correctly.
- Assert rst_n=0 after 2 of 4 flits of a packet -> outputs immediately reach reset values, count=0. Next packet after release routes normally.

Source files
------------

// File: rtl/noc_input_port_if.sv
// rtl/noc_input_port_if.sv - flit streams between upstream link, input port and output demux

interface noc_input_port_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_head;
    logic              in_tail;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_head;
    logic              out_tail;
    logic [2:0]        out_sel;

    // slave is the input port itself; master is the surrounding link/demux side
    modport slave (
        input  in_valid, in_data, in_head, in_tail,
        output in_ready,
        output out_valid, out_data, out_head, out_tail, out_sel,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_head, in_tail,
        input  in_ready,
        input  out_valid, out_data, out_head, out_tail, out_sel,
        output out_ready
    );
endinterface

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - router input port: flit FIFO, XY routing and wormhole output lock

module noc_input_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    noc_input_port_if.slave          bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FLIT_W = DATA_W + 2;

    localparam logic [X_W-1:0] CUR_XV = X_W'(CUR_X);
    localparam logic [Y_W-1:0] CUR_YV = Y_W'(CUR_Y);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    state_t            state;
    logic              first_flit;
    logic [2:0]        sel_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              fwd_pop;
    logic              drop_pop;
    logic              pop;
    logic [FLIT_W-1:0] front;
    logic              front_head;
    logic              front_tail;
    logic              out_valid_int;

    function automatic logic [2:0] route(input logic [DATA_W-1:0] d);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = d[X_W+Y_W-1:Y_W];
        dy = d[Y_W-1:0];
        if (dx > CUR_XV)      return 3'b010;
        else if (dx < CUR_XV) return 3'b100;
        else if (dy > CUR_YV) return 3'b001;
        else if (dy < CUR_YV) return 3'b011;
        else                  return 3'b000;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign front      = mem[rd_ptr];
    assign front_head = front[1];
    assign front_tail = front[0];

    assign push          = bus.in_valid && !full;
    assign out_valid_int = (state == ACTIVE) && !empty;
    assign fwd_pop       = out_valid_int && bus.out_ready;
    // A headless flit at the front while idle has no route; it is dropped
    assign drop_pop      = (state == IDLE) && !empty && !front_head;
    assign pop           = fwd_pop || drop_pop;

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = front[FLIT_W-1:2];
    assign bus.out_head  = front_head;
    assign bus.out_tail  = front_tail;
    assign bus.out_sel   = sel_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_data, bus.in_head, bus.in_tail};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= 3'b000;
            busy       <= 1'b0;
            err        <= 1'b0;
            first_flit <= 1'b0;
        end else if (state == IDLE) begin
            if (!empty) begin
                if (front_head) begin
                    sel_q      <= route(front[FLIT_W-1:2]);
                    state      <= ACTIVE;
                    busy       <= 1'b1;
                    first_flit <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end else begin
            if (fwd_pop) begin
                first_flit <= 1'b0;
                // A second head inside a locked packet is forwarded but flagged
                if (front_head && !first_flit) err <= 1'b1;
                if (front_tail) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - directed self-checking bench for noc_input_port at router (1,1)

module tb_noc_input_port;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [2:0] count;
    logic       err;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    typedef struct {
        logic [31:0] data;
        logic        head;
        logic        tail;
        logic [2:0]  sel;
        int          cyc;
    } pop_t;
    pop_t popq[$];

    noc_input_port_if #(.DATA_W(32)) bus ();

    noc_input_port #(
        .DATA_W(32), .DEPTH(4), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready)
            popq.push_back('{bus.out_data, bus.out_head, bus.out_tail, bus.out_sel, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] tag, input int x, input int y);
        logic [1:0] xv;
        logic [1:0] yv;
        xv = x[1:0];
        yv = y[1:0];
        return {tag, 20'h0, xv, yv};
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the flit was accepted
    task automatic send_flit(input logic [31:0] d, input logic h, input logic t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_head  = h;
        bus.in_tail  = t;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input string tag, input int n);
        int t = 0;
        while (popq.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(tag, 32'(popq.size() >= n), 32'd1);
    endtask

    logic [31:0] exp_d [12];
    logic [2:0]  exp_s [4];
    logic [31:0] f4d [6];
    int          xs [4];
    int          ys [4];

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_head   = 1'b0;
        bus.in_tail   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sel", 32'(bus.out_sel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // single-flit packet to (3,1): east, visible two cycles after push
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(8'hAB, 3, 1);
        bus.in_head   = 1'b1;
        bus.in_tail   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sp_count1", 32'(count), 32'd1);
        check("sp_novalid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("sp_valid", 32'(bus.out_valid), 32'd1);
        check("sp_sel", 32'(bus.out_sel), 32'b010);
        check("sp_busy", 32'(busy), 32'd1);
        check("sp_data", bus.out_data, mk(8'hAB, 3, 1));
        @(negedge clk);
        check("sp_valid_end", 32'(bus.out_valid), 32'd0);
        check("sp_busy_end", 32'(busy), 32'd0);
        check("sp_count_end", 32'(count), 32'd0);
        @(posedge clk);
        #1;

        // four 3-flit packets: west, north, south, local
        popq.delete();
        xs = '{0, 1, 1, 1};
        ys = '{1, 2, 0, 1};
        exp_s = '{3'b100, 3'b001, 3'b011, 3'b000};
        for (int p = 0; p < 4; p++) begin
            for (int f = 0; f < 3; f++) begin
                exp_d[p*3+f] = (f == 0) ? mk(8'(32 + p), xs[p], ys[p])
                                        : 32'h3000_0000 + 32'(p * 256 + f);
                send_flit(exp_d[p*3+f], f == 0, f == 2);
            end
        end
        bus.in_valid = 1'b0;
        wait_pops("mp_timeout", 12);
        for (int i = 0; i < popq.size() && i < 12; i++) begin
            check($sformatf("mp_data%0d", i), popq[i].data, exp_d[i]);
            check($sformatf("mp_sel%0d", i), 32'(popq[i].sel), 32'(exp_s[i/3]));
            if (i > 0)
                check($sformatf("mp_gap%0d", i), 32'(popq[i].cyc - popq[i-1].cyc),
                      (i % 3 == 0) ? 32'd2 : 32'd1);
        end
        check("mp_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // stall with a full FIFO, then pop-while-full and drain
        popq.delete();
        bus.out_ready = 1'b0;
        f4d[0] = mk(8'h40, 1, 2);
        for (int i = 1; i < 6; i++) f4d[i] = 32'h4100_0000 + 32'(i);
        for (int i = 0; i < 4; i++) send_flit(f4d[i], i == 0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_valid%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall_data%0d", k), bus.out_data, f4d[0]);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = f4d[4];
        bus.in_head   = 1'b0;
        bus.in_tail   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pwf_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("pwf_count", 32'(count), 32'd3);
        @(posedge clk);
        #1;
        send_flit(f4d[5], 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        wait_pops("drain_timeout", 6);
        check("drain_n", 32'(popq.size()), 32'd6);
        for (int i = 0; i < popq.size() && i < 6; i++) begin
            check($sformatf("drain_data%0d", i), popq[i].data, f4d[i]);
            check($sformatf("drain_sel%0d", i), 32'(popq[i].sel), 32'b001);
        end
        @(posedge clk);
        #1;

        // stray body flit while idle is dropped and flags err
        popq.delete();
        send_flit(32'h5000_0000, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_err", 32'(err), 32'd1);
        check("stray_count", 32'(count), 32'd0);
        check("stray_nopop", 32'(popq.size()), 32'd0);
        @(posedge clk);
        #1;
        send_flit(mk(8'h51, 1, 2), 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        wait_pops("stray_timeout", 1);
        if (popq.size() > 0) begin
            check("stray_next_sel", 32'(popq[0].sel), 32'b001);
            check("stray_next_data", popq[0].data, mk(8'h51, 1, 2));
        end
        check("stray_err_sticky", 32'(err), 32'd1);

        // reset in the middle of a packet
        bus.out_ready = 1'b0;
        send_flit(mk(8'h60, 3, 3), 1'b1, 1'b0);
        send_flit(32'h6100_0001, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_sel", 32'(bus.out_sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        popq.delete();
        bus.out_ready = 1'b1;
        send_flit(mk(8'h62, 1, 0), 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        wait_pops("post_rst_timeout", 1);
        repeat (3) @(negedge clk);
        check("post_rst_n", 32'(popq.size()), 32'd1);
        if (popq.size() > 0) begin
            check("post_rst_sel", 32'(popq[0].sel), 32'b011);
            check("post_rst_data", popq[0].data, mk(8'h62, 1, 0));
        end
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
